deser_frame_aligner: RTL

DESER_FRAME_ALIGNER -- requirements
Module: deser_frame_aligner

---
 rtl/aligner_pkg.sv | 12 +
 rtl/aligner_fifo.sv | 62 ++++++
 rtl/deser_frame_aligner.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/aligner_pkg.sv
// Shared types and constants for the deserializer frame aligner.
package aligner_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hA5C3;

endpackage

// File: rtl/aligner_fifo.sv
// Small synchronous FIFO holding {sof, payload} entries for the aligner.
// A write to a full FIFO is accepted when a read happens in the same cycle;
// otherwise it is dropped and flagged on o_drop.
module aligner_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_empty;
  logic             r_full;

  logic             w_pop;
  logic             w_push;
  logic [AW:0]      w_count_nxt;

  assign w_pop       = i_rd_en && !r_empty;
  assign w_push      = i_wr_en && (!r_full || w_pop);
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_empty   = r_empty;
  assign o_full    = r_full;
  assign o_drop    = i_wr_en && r_full && !w_pop;

  // Storage, pointers and registered empty/full flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/deser_frame_aligner.sv
// Frame aligner for a bit-serial deserializer window: hunts for the sync
// word, confirms it one frame later, then emits payload words into an
// output FIFO while tracking missed sync words.
// Optional build macro: ALIGNER_STATS_EN adds sync_err_cnt / lock_loss_cnt.
module deser_frame_aligner
  import aligner_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD   = DATA_WIDTH'(DEFAULT_SYNC_WORD),
  parameter int unsigned           FRAME_WORDS = 4,
  parameter int unsigned           MISS_LIMIT  = 2,
  parameter int unsigned           FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din_word,
  output logic [DATA_WIDTH-1:0] word_out,
  output logic                  word_sof,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  locked,
  output logic                  overflow
`ifdef ALIGNER_STATS_EN
  ,
  output logic [15:0]           sync_err_cnt,
  output logic [7:0]            lock_loss_cnt
`endif
);

  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam int unsigned IW = $clog2(FRAME_WORDS + 1);
  localparam int unsigned MW = $clog2(MISS_LIMIT + 1);

  state_t          r_state;
  logic [BW-1:0]   r_bit_cnt;
  logic [IW-1:0]   r_idx;
  logic [MW-1:0]   r_miss;
  logic            r_locked;
  logic            r_overflow;

  logic            w_boundary;
  logic            w_sync_pos;
  logic            w_match;
  logic            w_push;
  logic            w_sync_miss;
  logic            w_lock_loss;
  logic            w_empty;
  logic            w_full;
  logic            w_drop;
  logic [DATA_WIDTH:0] w_rd_data;

  assign w_match     = (din_word == SYNC_WORD);
  assign w_boundary  = (r_state != HUNT) && (r_bit_cnt == BW'(DATA_WIDTH - 1));
  assign w_sync_pos  = (r_idx == IW'(FRAME_WORDS));
  assign w_push      = (r_state == LOCKED) && w_boundary && !w_sync_pos;
  assign w_sync_miss = (r_state == LOCKED) && w_boundary && w_sync_pos && !w_match;
  assign w_lock_loss = w_sync_miss && (r_miss == MW'(MISS_LIMIT - 1));

  // Alignment FSM: bit/word position tracking, miss counting, lock flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= HUNT;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_miss    <= '0;
      r_locked  <= 1'b0;
    end else begin
      if (r_state != HUNT) begin
        r_bit_cnt <= w_boundary ? '0 : r_bit_cnt + BW'(1);
        if (w_boundary) r_idx <= w_sync_pos ? '0 : r_idx + IW'(1);
      end
      case (r_state)
        HUNT: begin
          if (w_match) begin
            r_state   <= CONFIRM;
            r_bit_cnt <= '0;
            r_idx     <= '0;
          end
        end
        CONFIRM: begin
          if (w_boundary && w_sync_pos) begin
            if (w_match) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_state <= HUNT;
            end
          end
        end
        LOCKED: begin
          if (w_boundary && w_sync_pos) begin
            if (w_match) begin
              r_miss <= '0;
            end else if (w_lock_loss) begin
              r_miss   <= '0;
              r_state  <= HUNT;
              r_locked <= 1'b0;
            end else begin
              r_miss <= r_miss + MW'(1);
            end
          end
        end
        default: begin
          r_state  <= HUNT;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag for payload words lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (!resetn)     r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  aligner_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .i_wr_en   (w_push),
    .i_wr_data ({(r_idx == '0), din_word}),
    .i_rd_en   (word_ready),
    .o_rd_data (w_rd_data),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_drop    (w_drop)
  );

  assign word_out   = w_rd_data[DATA_WIDTH-1:0];
  assign word_sof   = w_rd_data[DATA_WIDTH];
  assign word_valid = !w_empty;
  assign locked     = r_locked;
  assign overflow   = r_overflow;

`ifdef ALIGNER_STATS_EN
  logic [15:0] r_sync_err;
  logic [7:0]  r_lock_loss;

  // Saturating counters of sync misses while locked and of lock losses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync_err  <= '0;
      r_lock_loss <= '0;
    end else begin
      if (w_sync_miss && (r_sync_err != '1)) r_sync_err  <= r_sync_err + 16'd1;
      if (w_lock_loss && (r_lock_loss != '1)) r_lock_loss <= r_lock_loss + 8'd1;
    end
  end

  assign sync_err_cnt  = r_sync_err;
  assign lock_loss_cnt = r_lock_loss;
`endif

endmodule
